// File: rtl/rst_ctrl_pkg.sv
// Shared types for the aux reset-request initiator: FSM state encoding and
// the bit positions of the request cause vector.
package rst_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_ASRT,
    S_WAIT_DEASRT,
    S_HOLDOFF
  } aux_state_t;

  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_WDT = 1;

endpackage

// File: rtl/aux_rst_req_gen_if.sv
// Request/feedback/status bundle between the reset-request initiator (slave)
// and the logic that issues requests and watches its status (master).
interface aux_rst_req_gen_if;
  logic       i_sw_req;
  logic       i_wdt_req;
  logic       i_rst_fb;
  logic       i_clr;
  logic       o_aux_rst;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_cause;
  logic       o_timeout;

  modport master (
    output i_sw_req, i_wdt_req, i_rst_fb, i_clr,
    input  o_aux_rst, o_busy, o_done, o_cause, o_timeout
  );

  modport slave (
    input  i_sw_req, i_wdt_req, i_rst_fb, i_clr,
    output o_aux_rst, o_busy, o_done, o_cause, o_timeout
  );
endinterface

// File: rtl/fb_sync.sv
// DEPTH-stage synchronizer for the reset-controller feedback; reset value is
// chosen by the parent so the chain powers up at the deasserted level.
module fb_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  // NOTE: non-blocking assignments keep every stage sampling its neighbour's
  // pre-edge value; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) chain <= {DEPTH{RST_VAL}};
    else        chain <= {chain[DEPTH-2:0], d};
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/aux_rst_req_gen.sv
// Turns sw/wdt reset requests into a fixed-width aux reset pulse, then checks
// that the controller's staged reset asserts and releases, with timeouts.
module aux_rst_req_gen
  import rst_ctrl_pkg::*;
#(
  parameter logic [7:0]  AUX_LEN     = 8'd4,
  parameter logic [15:0] TIMEOUT_LEN = 16'd1024,
  parameter logic [7:0]  HOLDOFF_LEN = 8'd8,
  parameter logic        FB_POL      = 1'b1,
  parameter logic [2:0]  SYNC_FLOPS  = 3'd2
) (
  input  logic             clk,
  input  logic             areset,
  aux_rst_req_gen_if.slave bus
);

  localparam logic [15:0] AUX_LOAD = {8'd0, AUX_LEN - 8'd1};
  localparam logic [15:0] TO_LOAD  = TIMEOUT_LEN - 16'd1;
  localparam logic [15:0] HO_LOAD  = {8'd0, HOLDOFF_LEN - 8'd1};

  aux_state_t  state, state_nx;
  logic [15:0] cnt, cnt_nx, cnt_dec;
  logic        cnt_zero;
  logic        pend, pend_nx;
  logic [1:0]  pend_cause, pend_cause_nx, cause_nx;
  logic [1:0]  req;
  logic        done_nx, to_set;
  logic        fb_raw, fb_s;

  fb_sync #(
    .DEPTH   (int'(SYNC_FLOPS)),
    .RST_VAL (~FB_POL)
  ) u_fb_sync (
    .clk    (clk),
    .areset (areset),
    .d      (bus.i_rst_fb),
    .q      (fb_raw)
  );

  assign fb_s = fb_raw ~^ FB_POL;

  always_comb begin
    req            = '0;
    req[CAUSE_SW]  = bus.i_sw_req;
    req[CAUSE_WDT] = bus.i_wdt_req;
  end

  // Saturating decrement: the counter parks at zero instead of wrapping.
  assign cnt_zero = (cnt == 16'd0);
  assign cnt_dec  = cnt_zero ? cnt : cnt - 16'd1;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt_dec;
    pend_nx       = pend;
    pend_cause_nx = pend_cause;
    cause_nx      = bus.o_cause;
    done_nx       = 1'b0;
    to_set        = 1'b0;

    if (state != S_IDLE && |req) begin
      pend_nx       = 1'b1;
      pend_cause_nx = pend_cause | req;
    end

    unique case (state)
      S_IDLE: begin
        if (|req) begin
          state_nx = S_ASSERT;
          cause_nx = req;
          cnt_nx   = AUX_LOAD;
        end
      end
      S_ASSERT: begin
        if (cnt_zero) begin
          state_nx = S_WAIT_ASRT;
          cnt_nx   = TO_LOAD;
        end
      end
      S_WAIT_ASRT: begin
        if (fb_s) begin
          state_nx = S_WAIT_DEASRT;
          cnt_nx   = TO_LOAD;
        end else if (cnt_zero) begin
          to_set   = 1'b1;
          state_nx = S_HOLDOFF;
          cnt_nx   = HO_LOAD;
        end
      end
      S_WAIT_DEASRT: begin
        if (!fb_s) begin
          done_nx  = 1'b1;
          state_nx = S_HOLDOFF;
          cnt_nx   = HO_LOAD;
        end else if (cnt_zero) begin
          to_set   = 1'b1;
          state_nx = S_HOLDOFF;
          cnt_nx   = HO_LOAD;
        end
      end
      S_HOLDOFF: begin
        // A request arriving on the exit edge is folded into this launch.
        if (cnt_zero) begin
          if (pend || |req) begin
            state_nx      = S_ASSERT;
            cause_nx      = pend_cause | req;
            cnt_nx        = AUX_LOAD;
            pend_nx       = 1'b0;
            pend_cause_nx = 2'b00;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: only real control state lives here and all of it is reset; the
  // block must come up idle after power-on regardless of the resets it drives.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state         <= S_IDLE;
      cnt           <= 16'd0;
      pend          <= 1'b0;
      pend_cause    <= 2'b00;
      bus.o_aux_rst <= 1'b0;
      bus.o_done    <= 1'b0;
      bus.o_cause   <= 2'b00;
      bus.o_timeout <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      pend          <= pend_nx;
      pend_cause    <= pend_cause_nx;
      bus.o_aux_rst <= (state_nx == S_ASSERT);
      bus.o_done    <= done_nx;
      bus.o_cause   <= cause_nx;
      bus.o_timeout <= to_set | (bus.o_timeout & ~bus.i_clr);
    end
  end

  assign bus.o_busy = (state != S_IDLE);

endmodule
